mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter serving instruction fetches and load/stores (loads take priority).
// Latency: reads complete N+2 cycles after acceptance, writes N+1 (N = bytes); done is a 1-cycle pulse.
// Backpressure: requests are held until done; stores to 0x3xxxx stall while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IF_RD = 2'd1;
    localparam logic [1:0] LS_RD = 2'd2;
    localparam logic [1:0] LS_WR = 2'd3;

    logic [1:0]  state;
    logic [2:0]  idx;       // cycle number k since acceptance
    logic [2:0]  len;       // byte count N of the current transaction
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] rbuf_next;
    logic [2:0]  ls_len;
    logic        wr_q;
    logic        io_stall;

    // The stall gates the strobe combinationally so a full buffer never sees a write.
    assign io_stall = (state == LS_WR) && (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign mem_wr   = wr_q & ~io_stall;

    always_comb begin
        ls_len = 3'd4;
        case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // Byte presented in cycle k-1 arrives in cycle k and lands in lane k-2.
    always_comb begin
        rbuf_next = rbuf;
        case (idx)
            3'd2:    rbuf_next[7:0]   = mem_din;
            3'd3:    rbuf_next[15:8]  = mem_din;
            3'd4:    rbuf_next[23:16] = mem_din;
            3'd5:    rbuf_next[31:24] = mem_din;
            default: rbuf_next = rbuf;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            idx      <= 3'd0;
            len      <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rbuf     <= 32'd0;
            wr_q     <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!if_done && !ls_done) begin
                        if (ls_req) begin
                            addr_q  <= ls_addr;
                            wdata_q <= ls_wdata;
                            len     <= ls_len;
                            idx     <= 3'd1;
                            rbuf    <= 32'd0;
                            mem_a   <= ls_addr;
                            if (ls_we) begin
                                state    <= LS_WR;
                                wr_q     <= 1'b1;
                                mem_dout <= ls_wdata[7:0];
                            end else begin
                                state <= LS_RD;
                            end
                        end else if (if_req && !clear) begin
                            addr_q <= if_addr;
                            len    <= 3'd4;
                            idx    <= 3'd1;
                            rbuf   <= 32'd0;
                            mem_a  <= if_addr;
                            state  <= IF_RD;
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    if (state == IF_RD && clear) begin
                        state <= IDLE;
                        idx   <= 3'd0;
                        mem_a <= 32'd0;
                    end else begin
                        rbuf <= rbuf_next;
                        idx  <= idx + 3'd1;
                        if (idx < len)
                            mem_a <= addr_q + {29'd0, idx};
                        else
                            mem_a <= 32'd0;
                        if (idx == len + 3'd1) begin
                            state <= IDLE;
                            idx   <= 3'd0;
                            if (state == IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= rbuf_next;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rbuf_next;
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (!io_stall) begin
                        if (idx == len) begin
                            state    <= IDLE;
                            idx      <= 3'd0;
                            wr_q     <= 1'b0;
                            mem_a    <= 32'd0;
                            mem_dout <= 8'd0;
                            ls_done  <= 1'b1;
                        end else begin
                            idx      <= idx + 3'd1;
                            mem_a    <= addr_q + {29'd0, idx};
                            mem_dout <= wdata_q[{idx[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
